// File: rtl/multiplier_pkg.sv
// Shared defaults for the board-level multiplier and its input front end.
package multiplier_pkg;

    localparam int SW_WIDTH_DEF        = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int SYNC_STAGES_DEF     = 2;

endpackage : multiplier_pkg

// File: rtl/debouncer.sv
// Synchronizes one raw pushbutton and accepts a new level only after it has
// disagreed with the current level for DEBOUNCE_CYCLES consecutive cycles.
module debouncer
    import multiplier_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   stable_r;
    logic                   rise_r;

    logic                   synced_s;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   stable_nxt_s;
    logic                   rise_nxt_s;

    assign synced_s = sync_r[SYNC_STAGES-1];

    // Metastability chain for the raw button.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Agreement clears the run count; a full run of disagreement flips the level.
    always_comb begin
        cnt_nxt_s    = cnt_r;
        stable_nxt_s = stable_r;
        rise_nxt_s   = 1'b0;
        if (synced_s == stable_r) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == CNT_LAST) begin
            stable_nxt_s = synced_s;
            cnt_nxt_s    = '0;
            rise_nxt_s   = synced_s;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Debounce state and registered rising-edge flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            stable_r <= stable_nxt_s;
            rise_r   <= rise_nxt_s;
        end
    end

    assign level_o = stable_r;
    assign rise_o  = rise_r;

endmodule : debouncer

// File: rtl/input_conditioner.sv
// Pin front end for the multiplier: synchronizes the slide switches and
// debounces the Run and Reset/Load/Clear buttons.
module input_conditioner
    import multiplier_pkg::*;
#(
    parameter int SW_WIDTH        = SW_WIDTH_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [SW_WIDTH-1:0] sw_raw_i,
    input  logic                run_btn_i,
    input  logic                rlc_btn_i,
    output logic [SW_WIDTH-1:0] sw_o,
    output logic                run_o,
    output logic                run_pulse_o,
    output logic                rlc_o
);

    logic rlc_rise_unused_s;

    // Switches are only sampled by the multiplier on Load/Run, so no debounce.
    for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw_sync
        logic [SYNC_STAGES-1:0] chain_r;

        // Per-bit synchronizer chain.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                chain_r <= '0;
            end else begin
                chain_r <= {chain_r[SYNC_STAGES-2:0], sw_raw_i[g]};
            end
        end

        assign sw_o[g] = chain_r[SYNC_STAGES-1];
    end

    debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_deb (
        .Clk     (Clk),
        .Reset   (Reset),
        .raw_i   (run_btn_i),
        .level_o (run_o),
        .rise_o  (run_pulse_o)
    );

    debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_rlc_deb (
        .Clk     (Clk),
        .Reset   (Reset),
        .raw_i   (rlc_btn_i),
        .level_o (rlc_o),
        .rise_o  (rlc_rise_unused_s)
    );

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Directed and randomized bench for input_conditioner with a sliding-window
// reference model of synchronization and debounce acceptance.
module tb_input_conditioner;

    localparam int SW = 8;
    localparam int SS = 2;
    localparam int DB = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [SW-1:0] sw_raw_i = '0;
    logic          run_btn_i = 1'b0;
    logic          rlc_btn_i = 1'b0;
    logic [SW-1:0] sw_o;
    logic          run_o;
    logic          run_pulse_o;
    logic          rlc_o;

    int tests = 0;
    int fails = 0;
    int first;
    int pulses;

    // Model: last SS raw samples, last DB synced samples per button (0=run, 1=rlc)
    logic [SW+1:0] raw_h [SS];
    bit            win   [2][DB];
    int            since [2];
    bit            lvl   [2];
    bit            rs    [2];

    input_conditioner #(
        .SW_WIDTH        (SW),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB)
    ) u_dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .sw_raw_i    (sw_raw_i),
        .run_btn_i   (run_btn_i),
        .rlc_btn_i   (rlc_btn_i),
        .sw_o        (sw_o),
        .run_o       (run_o),
        .run_pulse_o (run_pulse_o),
        .rlc_o       (rlc_o)
    );

    always #5 Clk = ~Clk;

    function automatic void model_reset();
        for (int i = 0; i < SS; i++) raw_h[i] = '0;
        for (int b = 0; b < 2; b++) begin
            since[b] = 0;
            lvl[b]   = 1'b0;
            rs[b]    = 1'b0;
            for (int k = 0; k < DB; k++) win[b][k] = 1'b0;
        end
    endfunction

    // A level is accepted once the last DB synced samples (since the previous
    // acceptance) all disagree with the current level.
    function automatic void model_step();
        logic [SW+1:0] pre;
        bit            s [2];
        bit            ok;
        pre  = raw_h[SS-1];
        s[0] = pre[1];
        s[1] = pre[0];
        for (int b = 0; b < 2; b++) begin
            for (int k = DB - 1; k > 0; k--) win[b][k] = win[b][k-1];
            win[b][0] = s[b];
            since[b]++;
            rs[b] = 1'b0;
            if (since[b] >= DB) begin
                ok = 1'b1;
                for (int k = 0; k < DB; k++) if (win[b][k] == lvl[b]) ok = 1'b0;
                if (ok) begin
                    lvl[b]   = s[b];
                    rs[b]    = s[b];
                    since[b] = 0;
                end
            end
        end
        for (int i = SS - 1; i > 0; i--) raw_h[i] = raw_h[i-1];
        raw_h[0] = {sw_raw_i, run_btn_i, rlc_btn_i};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sw_o", 32'(sw_o), 32'(raw_h[SS-1][SW+1:2]));
        chk("run_o", 32'(run_o), 32'(lvl[0]));
        chk("run_pulse_o", 32'(run_pulse_o), 32'(rs[0]));
        chk("rlc_o", 32'(rlc_o), 32'(lvl[1]));
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Reset) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Assert reset between edges and check outputs drop without a clock.
    task automatic async_reset();
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_sw", 32'(sw_o), 32'd0);
        chk("async_run", 32'(run_o), 32'd0);
        chk("async_pulse", 32'(run_pulse_o), 32'd0);
        chk("async_rlc", 32'(rlc_o), 32'd0);
    endtask

    initial begin
        int pat [11] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};

        // Reset then idle with every raw input high
        sw_raw_i  = 8'hFF;
        run_btn_i = 1'b1;
        rlc_btn_i = 1'b1;
        model_reset();
        #1;
        check_all();
        ticks(3);
        Reset = 1'b0;
        first = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 1) chk("sw_lat1", 32'(sw_o), 32'h00);
            if (e == 2) chk("sw_lat2", 32'(sw_o), 32'hFF);
            if (run_o && first == 0) first = e;
        end
        chk("idle_run_lat", 32'(first), 32'd6);
        chk("idle_rlc", 32'(rlc_o), 32'd1);

        // Switch sync, no intermediate value
        sw_raw_i = 8'hC5;
        ticks(3);
        sw_raw_i = 8'h07;
        tick();
        chk("sw_hold", 32'(sw_o), 32'hC5);
        tick();
        chk("sw_new", 32'(sw_o), 32'h07);

        // Clean Run press held 20 cycles, then release
        run_btn_i = 1'b0;
        rlc_btn_i = 1'b0;
        ticks(8);
        run_btn_i = 1'b1;
        first = 0;
        pulses = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (run_pulse_o) pulses++;
            if (run_o && first == 0) first = e;
        end
        chk("press_lat", 32'(first), 32'd6);
        chk("press_pulses", 32'(pulses), 32'd1);
        run_btn_i = 1'b0;
        first = 0;
        pulses = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (run_pulse_o) pulses++;
            if (!run_o && first == 0) first = e;
        end
        chk("release_lat", 32'(first), 32'd6);
        chk("release_pulses", 32'(pulses), 32'd0);

        // Bouncing Run press
        first = 0;
        pulses = 0;
        for (int e = 1; e <= 16; e++) begin
            run_btn_i = (e <= 11) ? pat[e-1][0] : 1'b1;
            tick();
            if (run_pulse_o) pulses++;
            if (run_o && first == 0) first = e;
        end
        chk("bounce_lat", 32'(first), 32'd11);
        chk("bounce_pulses", 32'(pulses), 32'd1);
        run_btn_i = 1'b0;
        ticks(10);

        // Glitch on Reset/Load/Clear
        rlc_btn_i = 1'b1;
        ticks(3);
        rlc_btn_i = 1'b0;
        ticks(8);
        chk("glitch_rlc", 32'(rlc_o), 32'd0);
        chk("glitch_cnt", 32'(u_dut.u_rlc_deb.cnt_r), 32'd0);

        // Reset mid-count and mid-pulse
        sw_raw_i = 8'h5A;
        ticks(3);
        run_btn_i = 1'b1;
        ticks(5);
        chk("midcount_cnt", 32'(u_dut.u_run_deb.cnt_r), 32'd3);
        async_reset();
        ticks(2);
        Reset = 1'b0;
        first = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (run_pulse_o) begin
                first = e;
                break;
            end
        end
        chk("fresh_pulse_lat", 32'(first), 32'd6);
        async_reset();
        ticks(1);
        Reset = 1'b0;
        first = 0;
        pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (run_pulse_o) begin
                pulses++;
                if (first == 0) first = e;
            end
        end
        chk("fresh_pulse_lat2", 32'(first), 32'd6);
        chk("fresh_pulses2", 32'(pulses), 32'd1);

        // Randomized traffic against the model
        run_btn_i = 1'b0;
        rlc_btn_i = 1'b0;
        ticks(8);
        for (int i = 0; i < 400; i++) begin
            sw_raw_i = 8'($urandom);
            if ($urandom_range(0, 5) == 0) run_btn_i = ~run_btn_i;
            if ($urandom_range(0, 5) == 0) rlc_btn_i = ~rlc_btn_i;
            if (i % 97 == 50) begin
                async_reset();
                tick();
                Reset = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_input_conditioner
